// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction/flag inputs and datapath control outputs of the multicycle controller
interface multicycle_control_unit_if #(parameter int ALUCTRL_W = 2);
  logic [26:0] instr;
  logic [3:0] alu_flags;
  logic pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;
  logic [ALUCTRL_W-1:0] alu_control;
  logic [3:0] flags;
  modport master (
    input  instr, alu_flags,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, reg_write, alu_control, flags
  );
  modport slave (
    output instr, alu_flags,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_src, reg_write, alu_control, flags
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing ARMv4-subset instructions over a shared ALU and memory
module multicycle_control_unit #(
  parameter int ALUCTRL_W = 2,
  parameter int MEM_WAIT  = 0
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;
  localparam logic [ALUCTRL_W-1:0] alu_add = '0;
  localparam logic [ALUCTRL_W-1:0] alu_sub = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] alu_and = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] alu_orr = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] alu_eor = ALUCTRL_W'(4);
  state_t state;
  logic [2:0] cnt;
  logic [3:0] flags, cond, cmd, rd;
  logic [1:0] op;
  logic i_bit, s_bit, u_bit, l_bit, last, cond_ex;
  logic n, z, c, v;
  logic dp_ok, arith, no_wr;
  logic [ALUCTRL_W-1:0] alu_op;
  logic pc_w, ir_w, mem_w, reg_w;
  // instr holds Instr[31:5], so bit k of the instruction sits at index k-5
  assign cond  = bus.instr[26:23];
  assign op    = bus.instr[22:21];
  assign i_bit = bus.instr[20];
  assign cmd   = bus.instr[19:16];
  assign u_bit = bus.instr[18];
  assign s_bit = bus.instr[15];
  assign l_bit = bus.instr[15];
  assign rd    = bus.instr[10:7];
  assign {n, z, c, v} = flags;
  assign last = cnt == 3'(MEM_WAIT);
  always_comb begin
    case (cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'ha: cond_ex = n == v;
      4'hb: cond_ex = n != v;
      4'hc: cond_ex = ~z & (n == v);
      4'hd: cond_ex = z | (n != v);
      4'he: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  always_comb begin
    dp_ok = 1'b1;
    arith = 1'b1;
    no_wr = 1'b0;
    alu_op = alu_add;
    case (cmd)
      4'b0100: alu_op = alu_add;
      4'b0010: alu_op = alu_sub;
      4'b1010: begin alu_op = alu_sub; no_wr = 1'b1; end
      4'b0000: begin alu_op = alu_and; arith = 1'b0; end
      4'b1100: begin alu_op = alu_orr; arith = 1'b0; end
      4'b0001: begin alu_op = alu_eor; arith = 1'b0; dp_ok = ALUCTRL_W == 3; end
      default: dp_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt <= '0;
      flags <= '0;
    end else begin
      case (state)
        FETCH: begin
          cnt <= last ? '0 : cnt + 3'd1;
          if (last) state <= DECODE;
        end
        DECODE: state <= op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH :
                         op == 2'b00 ? (i_bit ? EXECI : EXECR) : FETCH;
        MEMADR: state <= l_bit ? MEMREAD : MEMWRITE;
        MEMREAD: begin
          cnt <= last ? '0 : cnt + 3'd1;
          if (last) state <= MEMWB;
        end
        MEMWRITE: begin
          cnt <= last ? '0 : cnt + 3'd1;
          if (last) state <= FETCH;
        end
        EXECR, EXECI: begin
          // logic ops leave carry and overflow untouched
          if (s_bit && cond_ex && dp_ok)
            flags <= arith ? bus.alu_flags : {bus.alu_flags[3:2], flags[1:0]};
          state <= (no_wr || !dp_ok) ? FETCH : ALUWB;
        end
        default: state <= FETCH;
      endcase
    end
  end
  always_comb begin
    pc_w = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    bus.adr_src = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.imm_src = 2'b00;
    bus.alu_control = alu_add;
    case (state)
      FETCH, DECODE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.result_src = 2'b10;
        ir_w = state == FETCH && last;
        pc_w = state == FETCH && last;
      end
      MEMADR: begin
        bus.alu_src_b = 2'b01;
        bus.imm_src = 2'b01;
        bus.alu_control = u_bit ? alu_add : alu_sub;
      end
      MEMREAD: bus.adr_src = 1'b1;
      MEMWRITE: begin
        bus.adr_src = 1'b1;
        mem_w = cond_ex && last;
      end
      MEMWB, ALUWB: begin
        bus.result_src = state == MEMWB ? 2'b01 : 2'b00;
        pc_w = cond_ex && rd == 4'hf;
        reg_w = cond_ex && rd != 4'hf;
      end
      EXECR, EXECI: begin
        bus.alu_src_b = state == EXECI ? 2'b01 : 2'b00;
        bus.alu_control = alu_op;
      end
      BRANCH: begin
        bus.imm_src = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.result_src = 2'b10;
        pc_w = cond_ex;
      end
      default: ;
    endcase
  end
  // enables are held off for the whole time reset is asserted
  assign bus.pc_write = pc_w & rst_n;
  assign bus.ir_write = ir_w & rst_n;
  assign bus.mem_write = mem_w & rst_n;
  assign bus.reg_write = reg_w & rst_n;
  assign bus.reg_src = {op == 2'b01 && !l_bit, op == 2'b10};
  assign bus.flags = flags;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-instruction enable timing, latency and flag checks on three configurations
module tb_multicycle_control_unit;
  typedef struct {
    bit rst;
    int d;
    logic [31:0] ins;
    logic [3:0] af;
    int cyc, ir, pc, rw, mw;
    logic [3:0] fl;
    int alu;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  bit carry = 0;
  vec_t tab[$];
  vec_t exp_q[$];
  multicycle_control_unit_if #(.ALUCTRL_W(2)) b0 ();
  multicycle_control_unit_if #(.ALUCTRL_W(2)) b1 ();
  multicycle_control_unit_if #(.ALUCTRL_W(3)) b2 ();
  multicycle_control_unit #(.ALUCTRL_W(2), .MEM_WAIT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  multicycle_control_unit #(.ALUCTRL_W(2), .MEM_WAIT(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  multicycle_control_unit #(.ALUCTRL_W(3), .MEM_WAIT(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  logic [2:0] irw, pcw, rgw, mmw, asa;
  logic [3:0] flg [3];
  logic [2:0] aluc [3];
  assign irw = {b2.ir_write, b1.ir_write, b0.ir_write};
  assign pcw = {b2.pc_write, b1.pc_write, b0.pc_write};
  assign rgw = {b2.reg_write, b1.reg_write, b0.reg_write};
  assign mmw = {b2.mem_write, b1.mem_write, b0.mem_write};
  assign asa = {b2.alu_src_a, b1.alu_src_a, b0.alu_src_a};
  assign flg[0] = b0.flags;
  assign flg[1] = b1.flags;
  assign flg[2] = b2.flags;
  assign aluc[0] = {1'b0, b0.alu_control};
  assign aluc[1] = {1'b0, b1.alu_control};
  assign aluc[2] = b2.alu_control;
  always #5 clk = ~clk;
  function automatic vec_t vt(bit rst, int d, logic [31:0] ins, logic [3:0] af, int cyc,
                              int ir, int pc, int rw, int mw, logic [3:0] fl, int alu);
    vec_t r;
    r.rst = rst; r.d = d; r.ins = ins; r.af = af; r.cyc = cyc;
    r.ir = ir; r.pc = pc; r.rw = rw; r.mw = mw; r.fl = fl; r.alu = alu;
    return r;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  task automatic drive(input int d, input logic [31:0] ins, input logic [3:0] af);
    case (d)
      0: begin b0.instr = ins[31:5]; b0.alu_flags = af; end
      1: begin b1.instr = ins[31:5]; b1.alu_flags = af; end
      default: begin b2.instr = ins[31:5]; b2.alu_flags = af; end
    endcase
  endtask
  task automatic do_reset(input int d);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("dut%0d reset enables", d), {irw[d], pcw[d], rgw[d], mmw[d]}, 0);
    chk($sformatf("dut%0d reset flags", d), flg[d], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    carry = 0;
  endtask
  task automatic run(input int idx, input vec_t v);
    int w, c, ir, pc, rw, mw, alu;
    bit done;
    vec_t e;
    string t;
    if (v.rst) do_reset(v.d);
    w = v.d == 1 ? 2 : 0;
    drive(v.d, v.ins, v.af);
    exp_q.push_back(v);
    c = 0; ir = 0; pc = 0; rw = 0; mw = 0; alu = 7; done = 0;
    while (!done && c < 24) begin
      if (!carry) @(negedge clk);
      carry = 0;
      c++;
      // a fetch-like cycle after decode marks the next instruction's first FETCH cycle
      if (c > w + 2 && asa[v.d]) begin
        done = 1;
        carry = 1;
      end else begin
        if (irw[v.d]) ir |= 1 << (c - 1);
        if (pcw[v.d]) pc |= 1 << (c - 1);
        if (rgw[v.d]) rw |= 1 << (c - 1);
        if (mmw[v.d]) mw |= 1 << (c - 1);
        if (c == w + 3) alu = aluc[v.d];
      end
    end
    e = exp_q.pop_front();
    t = $sformatf("row%0d %08h", idx, e.ins);
    chk({t, " done"}, done, 1);
    chk({t, " cycles"}, c - 1, e.cyc);
    chk({t, " ir_write"}, ir, e.ir);
    chk({t, " pc_write"}, pc, e.pc);
    chk({t, " reg_write"}, rw, e.rw);
    chk({t, " mem_write"}, mw, e.mw);
    chk({t, " flags"}, flg[v.d], e.fl);
    if (e.alu != 7) chk({t, " alu_control"}, alu, e.alu);
  endtask
  initial begin
    bit seen;
    drive(0, 32'hEC000000, 4'h0);
    drive(1, 32'hEC000000, 4'h0);
    drive(2, 32'hEC000000, 4'h0);
    //              rst d  instr         af     cyc ir    pc     rw     mw    flags  alu
    tab.push_back(vt(1, 0, 32'hE2821005, 4'h8, 4, 1, 1, 8, 0, 4'h0, 0));
    tab.push_back(vt(0, 0, 32'hE1510001, 4'h4, 3, 1, 1, 0, 0, 4'h4, 1));
    tab.push_back(vt(0, 0, 32'h1AFFFFFE, 4'h0, 3, 1, 1, 0, 0, 4'h4, 0));
    tab.push_back(vt(0, 0, 32'h0AFFFFFE, 4'h0, 3, 1, 5, 0, 0, 4'h4, 0));
    tab.push_back(vt(0, 0, 32'hE1510001, 4'h2, 3, 1, 1, 0, 0, 4'h2, 1));
    tab.push_back(vt(0, 0, 32'h02821005, 4'hF, 4, 1, 1, 0, 0, 4'h2, 0));
    tab.push_back(vt(0, 0, 32'hE282F004, 4'h0, 4, 1, 9, 0, 0, 4'h2, 0));
    tab.push_back(vt(0, 0, 32'hE2111000, 4'hD, 4, 1, 1, 8, 0, 4'hE, 2));
    tab.push_back(vt(0, 0, 32'hE2921005, 4'h3, 4, 1, 1, 8, 0, 4'h3, 0));
    tab.push_back(vt(0, 0, 32'hEC000000, 4'hF, 2, 1, 1, 0, 0, 4'h3, 7));
    tab.push_back(vt(0, 0, 32'hE1B01002, 4'hF, 3, 1, 1, 0, 0, 4'h3, 7));
    tab.push_back(vt(0, 0, 32'hBAFFFFFE, 4'h0, 3, 1, 5, 0, 0, 4'h3, 0));
    tab.push_back(vt(0, 0, 32'hCAFFFFFE, 4'h0, 3, 1, 1, 0, 0, 4'h3, 0));
    tab.push_back(vt(0, 0, 32'hE1821003, 4'h0, 4, 1, 1, 8, 0, 4'h3, 3));
    tab.push_back(vt(0, 0, 32'hE0221003, 4'h0, 3, 1, 1, 0, 0, 4'h3, 7));
    tab.push_back(vt(0, 0, 32'hF2821005, 4'h0, 4, 1, 1, 0, 0, 4'h3, 0));
    tab.push_back(vt(0, 0, 32'hE5910000, 4'h0, 5, 1, 1, 16, 0, 4'h3, 0));
    tab.push_back(vt(0, 0, 32'hE5110000, 4'h0, 5, 1, 1, 16, 0, 4'h3, 1));
    tab.push_back(vt(0, 0, 32'hE5810000, 4'h0, 4, 1, 1, 0, 8, 4'h3, 0));
    tab.push_back(vt(0, 0, 32'h05810000, 4'h0, 4, 1, 1, 0, 0, 4'h3, 0));
    tab.push_back(vt(1, 1, 32'hE5910000, 4'h0, 9, 4, 4, 256, 0, 4'h0, 0));
    tab.push_back(vt(0, 1, 32'hE5810000, 4'h0, 8, 4, 4, 0, 128, 4'h0, 0));
    tab.push_back(vt(0, 1, 32'hE2821005, 4'h0, 6, 4, 4, 32, 0, 4'h0, 0));
    tab.push_back(vt(0, 1, 32'hEAFFFFFE, 4'h0, 5, 4, 20, 0, 0, 4'h0, 0));
    tab.push_back(vt(0, 1, 32'hE591F000, 4'h0, 9, 4, 260, 0, 0, 4'h0, 0));
    tab.push_back(vt(1, 2, 32'hE0221003, 4'h0, 4, 1, 1, 8, 0, 4'h0, 4));
    tab.push_back(vt(0, 2, 32'hE2821005, 4'h0, 4, 1, 1, 8, 0, 4'h0, 0));
    tab.push_back(vt(0, 2, 32'hE0321003, 4'hB, 4, 1, 1, 8, 0, 4'h8, 4));
    tab.push_back(vt(1, 1, 32'hE1510001, 4'h4, 5, 4, 4, 0, 0, 4'h4, 1));
    tab.push_back(vt(0, 1, 32'hE2821005, 4'h0, 6, 4, 4, 32, 0, 4'h0, 0));
    for (int i = 0; i < tab.size() - 1; i++) run(i, tab[i]);
    // pull reset in the middle of a store's final MEMWRITE cycle
    drive(1, 32'hE5810000, 4'h0);
    seen = 0;
    for (int k = 0; k < 24 && !seen; k++) begin
      if (!carry) @(negedge clk);
      carry = 0;
      seen = mmw[1];
    end
    chk("midreset mem_write reached", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset mem_write", mmw[1], 0);
    chk("midreset other enables", {irw[1], pcw[1], rgw[1]}, 0);
    chk("midreset flags", flg[1], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    carry = 0;
    run(tab.size() - 1, tab[tab.size() - 1]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
